// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I encodings for the memory stage: ResultSrc,
//               LoadControl and StoreControl field values, plus the memory
//               access FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // ResultSrc selects what the writeback mux returns
    localparam logic [1:0] c_RES_ALU   = 2'b00;
    localparam logic [1:0] c_RES_LOAD  = 2'b01;
    localparam logic [1:0] c_RES_PC4   = 2'b10;
    localparam logic [1:0] c_RES_PCTGT = 2'b11;

    // Load width / signedness
    localparam logic [2:0] c_LD_LB  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LW  = 3'b010;
    localparam logic [2:0] c_LD_LBU = 3'b100;
    localparam logic [2:0] c_LD_LHU = 3'b101;

    // Store width
    localparam logic [2:0] c_ST_SB = 3'b000;
    localparam logic [2:0] c_ST_SH = 3'b001;
    localparam logic [2:0] c_ST_SW = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mau_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_if
// Description : Data-memory request/acknowledge port. The memory stage is
//               the master; the data memory (or its model) is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_load_extender.sv
`default_nettype none
// ============================================================================
// Module      : load_extender
// Description : Combinational load-data alignment. Picks the addressed byte
//               or halfword out of the read word and sign- or zero-extends
//               it; LW passes the word through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extender
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addrLo,
    input  logic [2:0]      loadCtrl,
    output logic [XLEN-1:0] extData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select on the low address bits, then extend by load type
    always_comb begin
        w_byte  = rdata[{addrLo, 3'b000} +: 8];
        w_half  = addrLo[1] ? rdata[31:16] : rdata[15:0];
        extData = rdata;
        case (loadCtrl)
            c_LD_LB:  extData = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_LD_LBU: extData = {{(XLEN-8){1'b0}}, w_byte};
            c_LD_LH:  extData = {{(XLEN-16){w_half[15]}}, w_half};
            c_LD_LHU: extData = {{(XLEN-16){1'b0}}, w_half};
            default:  extData = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : RV32I memory stage. Issues one request/acknowledge access per
//               load/store, builds store lanes and byte enables, extends load
//               data, stalls the front of the pipe while the access is
//               outstanding and owns the MEM/WB register.
//               Build option MEM_MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW
//               are dropped with a MisalignErrM pulse instead of being
//               silently aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        LoadControlM,
    input  logic [2:0]        StoreControlM,
    input  logic [4:0]        rdM,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   PCTargetM,
    mem_access_unit_if.master dmem,
    output logic              StallM,
    output logic              MisalignErrM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcW,
    output logic [4:0]        rdW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [XLEN-1:0]   PCTargetW
);

    mau_state_t        r_state;
    mau_state_t        w_stateNext;
    logic              w_memOp;
    logic              w_misalign;
    logic              w_issue;
    logic              w_stall;
    logic              w_misErr;
    logic              w_bubble;
    logic [3:0]        w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_ldExt;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_be;
    logic [1:0]        r_addrLo;
    logic [2:0]        r_loadCtrl;
    logic [XLEN-1:0]   r_rdBuf;

    assign w_memOp = MemWriteM | (ResultSrcM == c_RES_LOAD);

`ifdef MEM_MISALIGN_TRAP_EN
    // An access is misaligned when its low address bits exceed its natural size
    always_comb begin
        w_misalign = 1'b0;
        if (MemWriteM) begin
            case (StoreControlM)
                c_ST_SH: w_misalign = ALUResultM[0];
                c_ST_SW: w_misalign = |ALUResultM[1:0];
                default: w_misalign = 1'b0;
            endcase
        end else begin
            case (LoadControlM)
                c_LD_LH, c_LD_LHU: w_misalign = ALUResultM[0];
                c_LD_LW:           w_misalign = |ALUResultM[1:0];
                default:           w_misalign = 1'b0;
            endcase
        end
    end
`else
    // Without the trap, surplus low address bits are simply ignored
    assign w_misalign = 1'b0;
`endif

    // Store byte lanes: replicate narrow data across the word and enable the addressed lanes
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (StoreControlM)
            c_ST_SB: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {(XLEN/8){WriteDataM[7:0]}};
            end
            c_ST_SH: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {(XLEN/16){WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

    // Access FSM next state, issue strobe and stall; reset masks stall so outputs read 0
    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        w_stall     = 1'b0;
        w_misErr    = 1'b0;
        if (!RST) begin
            case (r_state)
                S_IDLE: begin
                    if (w_memOp && w_misalign) begin
                        w_misErr = 1'b1;
                    end else if (w_memOp) begin
                        w_stateNext = S_BUSY;
                        w_issue     = 1'b1;
                        w_stall     = 1'b1;
                    end
                end
                S_BUSY: begin
                    w_stall = 1'b1;
                    if (dmem.dmem_ack) begin
                        w_stateNext = S_DONE;
                    end
                end
                S_DONE:  w_stateNext = S_IDLE;
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    assign w_bubble     = w_stall | w_misErr;
    assign StallM       = w_stall;
    assign MisalignErrM = w_misErr;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Request register: capture the access at issue, hold it until acknowledged
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_addrLo   <= '0;
            r_loadCtrl <= '0;
            r_rdBuf    <= '0;
        end else if (w_issue) begin
            r_req      <= 1'b1;
            r_we       <= MemWriteM;
            r_addr     <= {ALUResultM[ADDR_W-1:2], 2'b00};
            r_wdata    <= w_wdata;
            r_be       <= w_be;
            r_addrLo   <= ALUResultM[1:0];
            r_loadCtrl <= LoadControlM;
        end else if ((r_state == S_BUSY) && dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_rdBuf <= w_ldExt;
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_be    = r_be;

    load_extender #(
        .XLEN (XLEN)
    ) u_load_extender (
        .rdata    (dmem.dmem_rdata),
        .addrLo   (r_addrLo),
        .loadCtrl (r_loadCtrl),
        .extData  (w_ldExt)
    );

    // MEM/WB register: bubble while stalled or trapped, otherwise take the M fields
    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= '0;
            rdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            PCTargetW  <= '0;
        end else begin
            RegWriteW  <= w_bubble ? 1'b0 : RegWriteM;
            rdW        <= w_bubble ? 5'd0 : rdM;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= r_rdBuf;
            PCPlus4W   <= PCPlus4M;
            PCTargetW  <= PCTargetM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed testbench for mem_access_unit. Covers ALU pass-through,
//               signed/unsigned sub-word loads, stores with lane replication,
//               a long-latency load, reset mid-access and misaligned access
//               (behaviour depends on MEM_MISALIGN_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import rv32i_pkg::*;

    logic        CLK;
    logic        RST;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadControlM, StoreControlM;
    logic [4:0]  rdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetM;
    logic        StallM, MisalignErrM, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  rdW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, PCTargetW;

    int nCmp = 0;
    int nErr = 0;

    mem_access_unit_if #(.ADDR_W(32), .XLEN(32)) dmem ();

    mem_access_unit #(.ADDR_W(32), .XLEN(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RegWriteM     (RegWriteM),
        .MemWriteM     (MemWriteM),
        .ResultSrcM    (ResultSrcM),
        .LoadControlM  (LoadControlM),
        .StoreControlM (StoreControlM),
        .rdM           (rdM),
        .ALUResultM    (ALUResultM),
        .WriteDataM    (WriteDataM),
        .PCPlus4M      (PCPlus4M),
        .PCTargetM     (PCTargetM),
        .dmem          (dmem),
        .StallM        (StallM),
        .MisalignErrM  (MisalignErrM),
        .RegWriteW     (RegWriteW),
        .ResultSrcW    (ResultSrcW),
        .rdW           (rdW),
        .ALUResultW    (ALUResultW),
        .ReadDataW     (ReadDataW),
        .PCPlus4W      (PCPlus4W),
        .PCTargetW     (PCTargetW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setNop();
        RegWriteM     = 1'b0;
        MemWriteM     = 1'b0;
        ResultSrcM    = c_RES_ALU;
        LoadControlM  = c_LD_LW;
        StoreControlM = c_ST_SW;
        rdM           = 5'd0;
        ALUResultM    = 32'h0;
        WriteDataM    = 32'h0;
        PCPlus4M      = 32'h0;
        PCTargetM     = 32'h0;
    endtask

    // One load or store: ack arrives on BUSY cycle number busyCycles
    task automatic memAccess(input string tag, input logic isStore, input logic [2:0] ctrl,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int busyCycles,
                             input logic [31:0] expRd, input logic [3:0] expBe,
                             input logic [31:0] expWdata, input int expStall);
        int stallCnt;
        stallCnt      = 0;
        RegWriteM     = !isStore;
        MemWriteM     = isStore;
        ResultSrcM    = isStore ? c_RES_ALU : c_RES_LOAD;
        LoadControlM  = ctrl;
        StoreControlM = ctrl;
        rdM           = isStore ? 5'd0 : 5'd7;
        ALUResultM    = addr;
        WriteDataM    = wdata;
        #1;
        stallCnt += int'(StallM);
        chk({tag, "_idle_req"}, 32'(dmem.dmem_req), 32'd0);
        tick();
        chk({tag, "_req"},  32'(dmem.dmem_req), 32'd1);
        chk({tag, "_we"},   32'(dmem.dmem_we), 32'(isStore));
        chk({tag, "_addr"}, dmem.dmem_addr, addr & 32'hFFFF_FFFC);
        if (isStore) begin
            chk({tag, "_be"},    32'(dmem.dmem_be), 32'(expBe));
            chk({tag, "_wdata"}, dmem.dmem_wdata, expWdata);
        end
        for (int i = 1; i <= busyCycles; i++) begin
            if (i == busyCycles) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = rdata;
            end
            #1;
            stallCnt += int'(StallM);
            chk({tag, "_busy_req"},  32'(dmem.dmem_req), 32'd1);
            chk({tag, "_busy_addr"}, dmem.dmem_addr, addr & 32'hFFFF_FFFC);
            chk({tag, "_busy_bubble"}, 32'(RegWriteW), 32'd0);
            tick();
            dmem.dmem_ack   = 1'b0;
            dmem.dmem_rdata = 32'h0;
        end
        #1;
        stallCnt += int'(StallM);
        chk({tag, "_done_req"}, 32'(dmem.dmem_req), 32'd0);
        chk({tag, "_stall_cycles"}, 32'(stallCnt), 32'(expStall));
        tick();
        setNop();
        chk({tag, "_regwriteW"}, 32'(RegWriteW), 32'(!isStore));
        if (!isStore) begin
            chk({tag, "_rdW"},       32'(rdW), 32'd7);
            chk({tag, "_readdataW"}, ReadDataW, expRd);
        end
    endtask

    initial begin
        setNop();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = 32'h0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_req",       32'(dmem.dmem_req), 32'd0);
        chk("rst_stall",     32'(StallM), 32'd0);
        chk("rst_regwriteW", 32'(RegWriteW), 32'd0);
        chk("rst_aluW",      ALUResultW, 32'd0);
        chk("rst_misalign",  32'(MisalignErrM), 32'd0);

        // ALU instruction passes straight through in one cycle
        RegWriteM  = 1'b1;
        ALUResultM = 32'h1234_5678;
        PCPlus4M   = 32'h0000_0104;
        rdM        = 5'd5;
        #1;
        chk("alu_stall", 32'(StallM), 32'd0);
        tick();
        setNop();
        chk("alu_aluW",      ALUResultW, 32'h1234_5678);
        chk("alu_rdW",       32'(rdW), 32'd5);
        chk("alu_regwriteW", 32'(RegWriteW), 32'd1);
        chk("alu_pc4W",      PCPlus4W, 32'h0000_0104);
        chk("alu_req",       32'(dmem.dmem_req), 32'd0);

        // Sub-word loads
        memAccess("lb",  1'b0, c_LD_LB,  32'h103, 32'h0, 32'h80FF_0000, 1, 32'hFFFF_FF80, 4'b0, 32'h0, 2);
        memAccess("lbu", 1'b0, c_LD_LBU, 32'h103, 32'h0, 32'h80FF_0000, 1, 32'h0000_0080, 4'b0, 32'h0, 2);
        memAccess("lh",  1'b0, c_LD_LH,  32'h102, 32'h0, 32'h8001_1234, 1, 32'hFFFF_8001, 4'b0, 32'h0, 2);
        memAccess("lhu", 1'b0, c_LD_LHU, 32'h100, 32'h0, 32'h0000_F00D, 1, 32'h0000_F00D, 4'b0, 32'h0, 2);

        // Stores
        memAccess("sh", 1'b1, c_ST_SH, 32'h202, 32'h0000_BEEF, 32'h0, 1, 32'h0, 4'b1100, 32'hBEEF_BEEF, 2);
        memAccess("sb", 1'b1, c_ST_SB, 32'h101, 32'h1234_56A5, 32'h0, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 2);
        memAccess("sw", 1'b1, c_ST_SW, 32'h300, 32'hCAFE_F00D, 32'h0, 2, 32'h0, 4'b1111, 32'hCAFE_F00D, 3);

        // Long-latency load: four BUSY cycles, five stall cycles
        memAccess("lw_slow", 1'b0, c_LD_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 4'b0, 32'h0, 5);

        // Reset while the access is outstanding
        RegWriteM    = 1'b1;
        ResultSrcM   = c_RES_LOAD;
        LoadControlM = c_LD_LW;
        ALUResultM   = 32'h440;
        rdM          = 5'd9;
        tick();
        chk("rstbusy_req_before", 32'(dmem.dmem_req), 32'd1);
        RST = 1'b1;
        tick();
        chk("rstbusy_req",       32'(dmem.dmem_req), 32'd0);
        chk("rstbusy_stall",     32'(StallM), 32'd0);
        chk("rstbusy_addr",      dmem.dmem_addr, 32'd0);
        chk("rstbusy_regwriteW", 32'(RegWriteW), 32'd0);
        chk("rstbusy_aluW",      ALUResultW, 32'd0);
        RST = 1'b0;
        setNop();
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'h1111_1111;
        #1;
        chk("late_ack_stall", 32'(StallM), 32'd0);
        tick();
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = 32'h0;
        chk("late_ack_req",  32'(dmem.dmem_req), 32'd0);
        chk("late_ack_stall2", 32'(StallM), 32'd0);

        // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
        RegWriteM    = 1'b1;
        ResultSrcM   = c_RES_LOAD;
        LoadControlM = c_LD_LW;
        ALUResultM   = 32'h101;
        rdM          = 5'd3;
        #1;
        chk("mis_pulse", 32'(MisalignErrM), 32'd1);
        chk("mis_stall", 32'(StallM), 32'd0);
        tick();
        setNop();
        chk("mis_req",       32'(dmem.dmem_req), 32'd0);
        chk("mis_regwriteW", 32'(RegWriteW), 32'd0);
        chk("mis_rdW",       32'(rdW), 32'd0);
        #1;
        chk("mis_pulse_end", 32'(MisalignErrM), 32'd0);
`else
        memAccess("lw_mis", 1'b0, c_LD_LW, 32'h101, 32'h0, 32'h55AA_33CC, 1, 32'h55AA_33CC, 4'b0, 32'h0, 2);
        chk("mis_pulse_off", 32'(MisalignErrM), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the RV32I five-stage pipeline. It consumes the EX/MEM pipeline register fields and runs a request/acknowledge transaction on the data-memory port. It also builds byte enables for stores, sign- or zero-extends load data, stalls the pipeline while an access is outstanding, and owns the MEM/WB pipeline register.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- XLEN, 32, data width

Ports (CLK, RST first):
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- RegWriteM, MemWriteM  in  1  EX/MEM control fields
- ResultSrcM  in  2  00 ALU, 01 load data, 10 PC+4, 11 PCTarget
- LoadControlM  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- StoreControlM  in  3  000 SB, 001 SH, 010 SW (EX/MEM register carries this field)
- rdM  in  5  destination register
- ALUResultM, WriteDataM, PCPlus4M, PCTargetM  in  XLEN  EX/MEM data fields
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  store when 1
- dmem_addr  out  ADDR_W  word-aligned address ({ALUResultM[31:2],2'b00})
- dmem_wdata  out  XLEN  store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  completion; dmem_rdata is valid in the same cycle
- dmem_rdata  in  XLEN  read data
- StallM  out  1  hold IF/ID/EX and EX/MEM
- MisalignErrM  out  1  one-cycle misalignment pulse (MEM_MISALIGN_TRAP_EN only)
- RegWriteW  out  1  MEM/WB field
- ResultSrcW  out  2  MEM/WB field
- rdW  out  5  MEM/WB field
- ALUResultW, ReadDataW, PCPlus4W, PCTargetW  out  XLEN  MEM/WB fields

## Operation
- MemOp = MemWriteM | (ResultSrcM==01).
- FSM states are IDLE, BUSY and DONE.
  - IDLE: MemOp=0 → stay; MEM/WB loads normally. MemOp=1 → go to BUSY, set dmem_req=1, latch dmem_we/addr/wdata/be, assert StallM.
  - BUSY: dmem_req held and outputs stable until dmem_ack. On ack: latch the extended rdata into a buffer, drop dmem_req, go to DONE. StallM stays high throughout BUSY.
  - DONE: StallM=0. MEM/WB loads the instruction with ReadDataW=buffer. Next state IDLE.
- Stores:
  - SB: be=1<<addr[1:0]; wdata has the byte replicated to all lanes.
  - SH: be=addr[1]?1100:0011; wdata has the halfword replicated.
  - SW: be=1111.
- Loads: select the byte at addr[1:0] or the halfword at addr[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.
- StallM=1 cycles: MEM/WB takes a bubble (RegWriteW=0, rdW=0); other W fields don't care.
- dmem_ack in IDLE or DONE is ignored.
- RST mid-transaction: FSM→IDLE and dmem_req=0 next edge. The memory side must tolerate an abandoned request.

## Timing
- Reset value of every output is 0, FSM in IDLE.
- Non-memory instruction: one cycle in M, no stall.
- Memory instruction with ack on the first BUSY cycle: three cycles in M (IDLE, BUSY, DONE), StallM high for two.
- Each extra cycle before ack adds one cycle.
- dmem_req rises the edge after the instruction enters M. It falls on the edge after ack.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, is not issued. In that case:
  - the FSM stays in IDLE;
  - MisalignErrM pulses for one cycle;
  - MEM/WB takes a bubble.
- Not defined: MisalignErrM is tied to 0. Low address bits beyond the access size are ignored (access is forced aligned) and the access proceeds normally.

## Structure
- Shared package rv32i_pkg holds:
  - the ResultSrc, LoadControl and StoreControl encodings as localparams;
  - the FSM state typedef (mau_state_t).
- Sub-module load_extender is combinational: (rdata, addr[1:0], LoadControl) → extended XLEN word.
- Store lane and byte-enable generation stays inline.

## Test plan
- ALU op, ALUResultM=0x12345678, rdM=5, RegWriteM=1 → next edge ALUResultW=0x12345678, rdW=5, RegWriteW=1, StallM never high.
- LB at addr 0x103, rdata=0x80FF_0000 with ack on the first BUSY cycle → StallM high 2 cycles, ReadDataW=0xFFFFFF80. With LBU → 0x00000080.
- SH at addr 0x202, WriteDataM=0x0000BEEF → dmem_be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1, dmem_addr=0x200.
- LW with ack delayed 4 cycles → dmem_req and dmem_addr stable the whole time, StallM high 5 cycles, W bubbles meanwhile, then RegWriteW=1.
- RST asserted during BUSY → dmem_req=0, StallM=0 and all outputs 0 next edge. A later ack is ignored.
- MEM_MISALIGN_TRAP_EN defined, LW at 0x101 → no dmem_req, one-cycle MisalignErrM pulse, RegWriteW=0. Undefined → access to 0x100 completes.
